// File: rtl/prach_hb5_sched.sv
// prach_hb5_sched: locks onto the 256-slot TDM stream, buffers even-frame samples, and
// emits (even, odd) pairs to hb5 on the odd frame. Optional channel mask: PRACH_HB5_SCHED_MASK_EN.
module prach_hb5_sched #(
  parameter int NUM_CHANNEL      = 256,
  parameter int NUM_CHANNEL_USED = 48,
  parameter int IDLE_CHN         = 255
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef PRACH_HB5_SCHED_MASK_EN
  input  logic [NUM_CHANNEL_USED-1:0] ch_mask,
`endif
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic signed [15:0]          in_data,
  input  logic [7:0]                  in_chn,
  input  logic                        in_sync,
  input  logic                        err_clr,
  output logic signed [15:0]          out_dp1,
  output logic signed [15:0]          out_dp2,
  output logic [7:0]                  out_chn,
  output logic                        out_sync,
  output logic                        busy,
  output logic                        err_align
);

  localparam int         AW        = $clog2(NUM_CHANNEL_USED);
  localparam logic [7:0] LAST_SLOT = 8'(NUM_CHANNEL - 1);
  localparam logic [7:0] USED_CHN  = 8'(NUM_CHANNEL_USED);
  localparam logic [7:0] IDLE_CODE = 8'(IDLE_CHN);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_EVEN, ST_ODD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_next;
  logic              w_err;
  logic              w_relock;
  logic              w_used;
  logic              w_wrap;
  logic              w_wr_en;
  logic              w_emit;
  logic              w_keep;
  logic [AW-1:0]     w_addr;

  logic signed [15:0] r_buf [0:NUM_CHANNEL_USED-1];
  logic signed [15:0] r_rd_data;

  logic               r_s1_emit;
  logic               r_s1_keep;
  logic               r_s1_sync;
  logic [7:0]         r_s1_chn;
  logic signed [15:0] r_s1_data;

  assign w_addr   = in_chn[AW-1:0];
  assign w_used   = (in_chn < USED_CHN);
  assign w_wrap   = (r_cnt == LAST_SLOT);
  assign w_relock = in_sync && (in_chn == 8'd0);
  // Alignment is only checked while locked; a sync beat is legal only at slot 0.
  assign w_err    = in_valid && ((r_state == ST_EVEN) || (r_state == ST_ODD)) &&
                    ((in_chn != r_cnt) || (in_sync && (r_cnt != 8'd0)));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wr_en      = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_next = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (in_valid && in_sync) begin
          w_state_next = ST_EVEN;
          w_cnt_next   = 8'd1;
          w_wr_en      = w_used;
        end
      end
      ST_EVEN, ST_ODD: begin
        if (w_err) begin
          if (w_relock) begin
            w_state_next = ST_EVEN;
            w_cnt_next   = 8'd1;
            w_wr_en      = w_used;
          end else begin
            w_state_next = ST_WAIT_SYNC;
          end
        end else if (in_valid) begin
          w_cnt_next = w_wrap ? 8'd0 : r_cnt + 8'd1;
          if (r_state == ST_EVEN) begin
            w_wr_en = w_used;
            if (w_wrap) w_state_next = ST_ODD;
          end else begin
            w_emit = w_used;
            if (w_wrap) w_state_next = enable ? ST_EVEN : ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef PRACH_HB5_SCHED_MASK_EN
  logic [NUM_CHANNEL_USED-1:0] r_mask;
  logic                        w_mask_load;

  // Mask is frozen for the whole odd frame so a mid-frame change cannot split the schedule.
  assign w_mask_load = (r_state == ST_EVEN) && (w_state_next == ST_ODD);
  assign w_keep      = r_mask[w_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_mask <= '1;
    else if (w_mask_load) r_mask <= ch_mask;
  end
`else
  assign w_keep = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_addr] <= in_data;
    r_rd_data <= r_buf[w_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      busy      <= 1'b0;
      err_align <= 1'b0;
      r_s1_emit <= 1'b0;
      r_s1_keep <= 1'b0;
      r_s1_sync <= 1'b0;
      r_s1_chn  <= IDLE_CODE;
      r_s1_data <= '0;
      out_dp1   <= '0;
      out_dp2   <= '0;
      out_chn   <= IDLE_CODE;
      out_sync  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      busy    <= (w_state_next != ST_IDLE);
      if (w_err)        err_align <= 1'b1;
      else if (err_clr) err_align <= 1'b0;

      // Stage 1 aligns the incoming sample with the registered buffer read.
      r_s1_emit <= w_emit;
      r_s1_keep <= w_keep;
      r_s1_sync <= (in_chn == 8'd0);
      r_s1_chn  <= in_chn;
      r_s1_data <= in_data;

      if (r_s1_emit) begin
        out_chn  <= r_s1_chn;
        out_sync <= r_s1_sync;
        out_dp1  <= r_s1_keep ? r_rd_data : '0;
        out_dp2  <= r_s1_keep ? r_s1_data : '0;
      end else begin
        out_chn  <= IDLE_CODE;
        out_sync <= 1'b0;
        out_dp1  <= '0;
        out_dp2  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prach_hb5_sched.sv
// Bench for prach_hb5_sched: a vector table for lock/error handling, then frame-level
// directed and random traffic checked against a per-beat behavioural model.
module tb_prach_hb5_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  in_chn;
  logic        in_sync;
  logic        err_clr;
  logic [15:0] out_dp1;
  logic [15:0] out_dp2;
  logic [7:0]  out_chn;
  logic        out_sync;
  logic        busy;
  logic        err_align;
  logic [47:0] tb_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int pairs_seen = 0;
  int syncs_seen = 0;

  always #5 clk = ~clk;

  prach_hb5_sched dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PRACH_HB5_SCHED_MASK_EN
    .ch_mask   (tb_mask),
`endif
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_chn    (in_chn),
    .in_sync   (in_sync),
    .err_clr   (err_clr),
    .out_dp1   (out_dp1),
    .out_dp2   (out_dp2),
    .out_chn   (out_chn),
    .out_sync  (out_sync),
    .busy      (busy),
    .err_align (err_align)
  );

  typedef struct {
    logic [7:0]  chn;
    logic [15:0] dp1;
    logic [15:0] dp2;
    bit          sync;
  } exp_t;

  typedef struct {
    bit          en;
    bit          v;
    bit          s;
    bit          clr;
    logic [7:0]  c;
    logic [15:0] d;
    bit          busy;
    bit          err;
  } vec_t;

  // Behavioural model: mode 0 idle, 1 hunting for sync, 2 even frame, 3 odd frame.
  int          m_mode;
  int          m_pos;
  bit          m_err;
  logic [15:0] m_store [48];
  logic [47:0] m_mask;
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pos  = 0;
    m_err  = 0;
    m_mask = '1;
    exp_q.delete();
  endtask

  task automatic ref_beat(input bit v, input logic [15:0] d, input int c, input bit s,
                          input bit en, input bit clr, output exp_t e);
    bit bad;
    e.chn = 8'd255; e.dp1 = '0; e.dp2 = '0; e.sync = 0;
    bad = 0;
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (v && s) begin
        m_mode = 2; m_pos = 1;
        if (c < 48) m_store[c] = d;
      end
    end else if (v) begin
      if (c != m_pos || (s && m_pos != 0)) begin
        bad = 1;
        if (s && c == 0) begin
          m_mode = 2; m_pos = 1; m_store[0] = d;
        end else begin
          m_mode = 1;
        end
      end else begin
        if (m_mode == 2) begin
          if (c < 48) m_store[c] = d;
        end else if (c < 48) begin
          e.chn  = 8'(c);
          e.sync = (c == 0);
          e.dp1  = m_mask[c] ? m_store[c] : 16'h0;
          e.dp2  = m_mask[c] ? d : 16'h0;
        end
        m_pos = (m_pos + 1) % 256;
        if (m_pos == 0) begin
          if (m_mode == 2) begin
            m_mode = 3; m_mask = tb_mask;
          end else begin
            m_mode = en ? 2 : 0;
          end
        end
      end
    end
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  // One clock: drive a beat, advance the model, compare outputs of the beat two cycles back.
  task automatic tick(input bit v, input logic [15:0] d, input logic [7:0] c, input bit s);
    exp_t e;
    exp_t old;
    in_valid = v; in_data = d; in_chn = c; in_sync = s;
    ref_beat(v, d, int'(c), s, enable, err_clr, e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("err_align", 32'(err_align), 32'(m_err));
    if (out_chn != 8'd255) pairs_seen++;
    if (out_sync) syncs_seen++;
    if (exp_q.size() >= 2) begin
      old = exp_q.pop_front();
      check("out_chn", 32'(out_chn), 32'(old.chn));
      check("out_sync", 32'(out_sync), 32'(old.sync));
      if (old.chn != 8'd255) begin
        check("out_dp1", 32'(out_dp1), 32'(old.dp1));
        check("out_dp2", 32'(out_dp2), 32'(old.dp2));
      end
    end
  endtask

  task automatic sync_reset();
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    check("rst_out_chn", 32'(out_chn), 32'd255);
    check("rst_out_dp1", 32'(out_dp1), 32'd0);
    check("rst_out_dp2", 32'(out_dp2), 32'd0);
    check("rst_out_sync", 32'(out_sync), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int base, input bit rnd, input int gap_chn, input int skip_chn,
                       input int drop_chn, input int rst_chn);
    for (int s = 0; s < 256; s++) begin
      logic [15:0] d;
      if (s == rst_chn) begin
        async_reset_check();
        return;
      end
      if (s == drop_chn) enable = 1'b0;
      if (s == gap_chn) repeat (3) tick(1'b0, 16'h0, 8'(s), 1'b0);
      if (rnd && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick(1'b0, 16'h0, 8'h0, 1'b0);
      if (s == skip_chn || (rnd && s != 0 && $urandom_range(0, 399) == 0)) continue;
      d = rnd ? 16'($urandom) : 16'(base + s);
      tick(1'b1, d, 8'(s), s == 0);
    end
  endtask

  vec_t tv [11];

  initial begin
    tv[0]  = '{en:0, v:1, s:1, clr:0, c:8'd0, d:16'd7,  busy:0, err:0};
    tv[1]  = '{en:1, v:0, s:0, clr:0, c:8'd0, d:16'd0,  busy:1, err:0};
    tv[2]  = '{en:1, v:1, s:0, clr:0, c:8'd0, d:16'd1,  busy:1, err:0};
    tv[3]  = '{en:1, v:1, s:1, clr:0, c:8'd0, d:16'd2,  busy:1, err:0};
    tv[4]  = '{en:1, v:1, s:0, clr:0, c:8'd1, d:16'd3,  busy:1, err:0};
    tv[5]  = '{en:1, v:1, s:0, clr:0, c:8'd3, d:16'd4,  busy:1, err:1};
    tv[6]  = '{en:1, v:1, s:0, clr:1, c:8'd4, d:16'd5,  busy:1, err:0};
    tv[7]  = '{en:1, v:1, s:1, clr:0, c:8'd0, d:16'd6,  busy:1, err:0};
    tv[8]  = '{en:1, v:1, s:1, clr:0, c:8'd0, d:16'd7,  busy:1, err:1};
    tv[9]  = '{en:1, v:1, s:0, clr:1, c:8'd1, d:16'd8,  busy:1, err:0};
    tv[10] = '{en:1, v:1, s:0, clr:1, c:8'd5, d:16'd9,  busy:1, err:1};

    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; in_chn = '0;
    in_sync = 1'b0; err_clr = 1'b0; tb_mask = '1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_chn", 32'(out_chn), 32'd255);
    check("reset_out_dp1", 32'(out_dp1), 32'd0);
    check("reset_out_dp2", 32'(out_dp2), 32'd0);
    check("reset_out_sync", 32'(out_sync), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err_align", 32'(err_align), 32'd0);
    rst = 1'b0;

    // Lock, alignment error, re-lock and clear priority, one clock per row.
    for (int i = 0; i < 11; i++) begin
      enable = tv[i].en; err_clr = tv[i].clr;
      in_valid = tv[i].v; in_sync = tv[i].s; in_chn = tv[i].c; in_data = tv[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("vec%0d_err", i), 32'(err_align), 32'(tv[i].err));
      check($sformatf("vec%0d_chn", i), 32'(out_chn), 32'd255);
    end
    err_clr = 1'b0;

    // Two clean frames: exactly 48 pairs and one sync pulse.
    sync_reset();
    enable = 1'b1;
    tick(1'b0, 16'h0, 8'h0, 1'b0);
    pairs_seen = 0; syncs_seen = 0;
    frame(1000, 0, -1, -1, -1, -1);
    check("even_pairs", 32'(pairs_seen), 32'd0);
    frame(2000, 0, -1, -1, -1, -1);
    check("odd_pairs", 32'(pairs_seen), 32'd48);
    check("odd_syncs", 32'(syncs_seen), 32'd1);

    // Valid gap mid-odd frame.
    frame(1100, 0, -1, -1, -1, -1);
    frame(2100, 0, 10, -1, -1, -1);
    check("gap_err", 32'(err_align), 32'd0);

    // Slot skip 20->22 in an even frame, recovery, then clear.
    frame(1200, 0, -1, 21, -1, -1);
    check("skip_err", 32'(err_align), 32'd1);
    frame(1300, 0, -1, -1, -1, -1);
    pairs_seen = 0;
    frame(2300, 0, -1, -1, -1, -1);
    check("relock_pairs", 32'(pairs_seen), 32'd48);
    err_clr = 1'b1;
    tick(1'b0, 16'h0, 8'h0, 1'b0);
    check("clr_err", 32'(err_align), 32'd0);

    // Enable dropped early in the even frame: odd frame still completes.
    frame(1400, 0, -1, -1, 5, -1);
    pairs_seen = 0;
    frame(2400, 0, -1, -1, -1, -1);
    check("drop_pairs", 32'(pairs_seen), 32'd48);
    frame(1500, 0, -1, -1, -1, -1);
    check("drop_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-odd, then restart from an even frame.
    enable = 1'b1;
    tick(1'b0, 16'h0, 8'h0, 1'b0);
    frame(1600, 0, -1, -1, -1, -1);
    frame(2600, 0, -1, -1, -1, 30);
    enable = 1'b1;
    tick(1'b0, 16'h0, 8'h0, 1'b0);
    pairs_seen = 0;
    frame(1700, 0, -1, -1, -1, -1);
    check("post_rst_even_pairs", 32'(pairs_seen), 32'd0);
    frame(2700, 0, -1, -1, -1, -1);

`ifdef PRACH_HB5_SCHED_MASK_EN
    tb_mask[7] = 1'b0;
    frame(1800, 0, -1, -1, -1, -1);
    tb_mask = '1;
    frame(2800, 0, -1, -1, -1, -1);
`endif

    // Random data, gaps, occasional slip and random enable per frame.
    for (int f = 0; f < 10; f++) begin
      enable = ($urandom_range(0, 3) != 0);
      frame(0, 1, -1, -1, -1, -1);
    end
    repeat (3) tick(1'b0, 16'h0, 8'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prach_hb5_sched.md
Name: prach_hb5_sched

Overview:
- Frame scheduler that feeds the PRACH decimate-by-2 halfband stage (hb5).
- Locks onto the upstream 256-slot TDM stream and buffers the even-frame sample of each used channel.
- On the following odd frame it emits (even, odd) sample pairs as dp1/dp2 with the channel index and a frame sync.
- Emits IDLE_CHN on every non-output cycle, so the hb5 delay lines shift only on real pairs.

Parameters:
- NUM_CHANNEL, 256, TDM slots per frame; slot counter wraps at NUM_CHANNEL-1.
- NUM_CHANNEL_USED, 48, slots 0..NUM_CHANNEL_USED-1 carry data; the rest are ignored.
- IDLE_CHN, 255, channel code driven when no pair is emitted; must be >= NUM_CHANNEL_USED.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled at frame boundaries.
- in_valid  in  1  upstream beat valid.
- in_data  in  16  upstream sample, signed.
- in_chn  in  8  upstream slot index.
- in_sync  in  1  upstream frame start; asserted with in_chn==0.
- err_clr  in  1  clears err_align.
- out_dp1  out  16  even-frame (older) sample.
- out_dp2  out  16  odd-frame (newer) sample.
- out_chn  out  8  channel of the pair, or IDLE_CHN.
- out_sync  out  1  pulse with the first pair (chn 0) of each output frame.
- busy  out  1  high in any state other than IDLE.
- err_align  out  1  sticky alignment error.

Behaviour:
- Reset values:
  - out_dp1=0, out_dp2=0, out_chn=IDLE_CHN, out_sync=0, busy=0, err_align=0.
  - Slot counter=0, state=IDLE.
  - Buffer contents don't-care; no pair is emitted before an EVEN frame is captured.
- States and transitions:
  - IDLE: enable=1 -> WAIT_SYNC.
  - WAIT_SYNC: valid in_sync beat -> EVEN; slot counter loaded with 1.
  - EVEN -> ODD: on counter wrap.
  - ODD -> EVEN: on counter wrap if enable=1; otherwise -> IDLE.
  - enable low mid-frame: the current EVEN+ODD pair completes and pairs are never split. Dropping enable during EVEN still finishes the ODD frame.
- Slot counter:
  - Advances only on in_valid beats.
  - Cycles with in_valid=0 produce out_chn=IDLE_CHN and do not advance the counter.
- Alignment check, on every valid beat while in EVEN or ODD:
  - Error condition: in_chn != counter, or in_sync=1 with counter != 0.
  - On error: set err_align and go to WAIT_SYNC.
  - The offending beat and the rest of the frame emit IDLE_CHN.
  - A correct in_sync in the same beat re-locks immediately, counter -> 1, next state EVEN.
- EVEN frame:
  - Valid beat with in_chn < NUM_CHANNEL_USED writes buffer[in_chn] = in_data.
  - Outputs stay idle.
- ODD frame:
  - Valid beat with in_chn < NUM_CHANNEL_USED emits out_dp1=buffer[in_chn], out_dp2=in_data, out_chn=in_chn.
  - out_sync=1 when in_chn==0.
  - Slots >= NUM_CHANNEL_USED emit IDLE_CHN.
- Latency: fixed 2 cycles from input beat to output (buffer read registered; in_data and chn delayed to match). Outputs are fully registered.
- err_align clear: cleared by err_clr. If err_clr coincides with a new error, set wins.
- Buffer: single-port-read / single-port-write distributed RAM, 48x16. Read and write never target the same frame, so no hazard.

Optional Feature:
- Macro PRACH_HB5_SCHED_MASK_EN.
- Defined:
  - Adds input port ch_mask [NUM_CHANNEL_USED-1:0].
  - Sampled once per frame at the EVEN->ODD transition.
  - Masked channels (bit=0) still emit out_chn=channel on schedule but with out_dp1=out_dp2=0, so hb5 cadence is preserved.
- Undefined: no port; all used channels pass.

Test Plan:
- Reset, enable=1, two clean frames (in_data = 1000+chn in EVEN, 2000+chn in ODD) -> no pairs during EVEN. In ODD, each chn 0..47 gives dp1=1000+chn, dp2=2000+chn, 2 cycles after input. out_sync only with chn 0. Slots 48..255 give out_chn=255.
- in_valid low for 3 cycles mid-ODD at chn 10 -> 3 idle outputs, then chn 10 pair emitted, no error.
- in_chn skips 20->22 in an EVEN frame -> err_align=1, outputs idle until next in_sync. Then a clean EVEN+ODD restores pairs. err_clr drops err_align.
- enable dropped at chn 5 of EVEN -> full ODD frame of 48 pairs emitted, then busy=0 and out_chn=255 thereafter.
- rst asserted mid-ODD at chn 30 -> outputs immediately at reset values. After release with enable=1, the first frame is EVEN (no pairs).
- With PRACH_HB5_SCHED_MASK_EN, ch_mask bit 7 = 0 -> chn 7 emitted with dp1=dp2=0, all other channels unchanged.
